// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store sequencer:
//   - access size encodings (byte/half/word/dword)
//   - sequencer state enumeration
//   - natural-alignment check helper
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_STROBE,
        ST_RD_CAPTURE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_RESP
    } state_t;

    // An access is legal only when its byte offset is a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = (offset[0] != 1'b0);
            SZ_WORD: bad = (offset[1:0] != 2'b00);
            default: bad = (offset != 3'b000);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for little-endian dword memory.
//   Extract path: pulls the addressed lane out of a dword and zero- or
//                 sign-extends it to DATA_W.
//   Merge path:   replaces the addressed lane of an old dword with the low
//                 bytes of the store data, leaving every other byte intact.
// Ports:
//   offset, size       - byte offset within the dword and access size
//   is_signed          - sign-extend extracted lane (ignored for dword)
//   ext_dword          - dword to extract from
//   ext_result         - extended load result
//   merge_old          - dword currently in memory
//   merge_wdata        - right-justified store data
//   merge_result       - dword to write back
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] ext_dword,
    output logic [DATA_W-1:0] ext_result,
    input  logic [DATA_W-1:0] merge_old,
    input  logic [DATA_W-1:0] merge_wdata,
    output logic [DATA_W-1:0] merge_result
);

    logic [5:0]        shift_amt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] merge_mask;
    logic              sign_bit;

    // lane_mask is the right-justified mask of the access size; it is shared
    // by both paths, shifted up to the lane position for the merge.
    always_comb begin
        shift_amt    = {offset, 3'b000};
        shifted      = ext_dword >> shift_amt;
        lane_mask    = '1;
        sign_bit     = 1'b0;
        case (size)
            SZ_BYTE: begin
                lane_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            SZ_HALF: begin
                lane_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            SZ_WORD: begin
                lane_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                lane_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        ext_result   = (shifted & lane_mask) |
                       ((is_signed && sign_bit) ? ~lane_mask : '0);
        merge_mask   = lane_mask << shift_amt;
        merge_result = (merge_old & ~merge_mask) |
                       ((merge_wdata & lane_mask) << shift_amt);
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store sequencer between the execute stage and Data_Memory. Accepts
// one byte-addressed access per handshake, drives Data_Memory with clean
// single-cycle MemRead/MemWrite pulses framed by a setup cycle and a hold
// cycle, performs read-modify-write for sub-dword stores and returns
// extended load data.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req_valid/req_ready            - request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_signed, req_addr, req_wdata - request fields
//   mem_address, mem_write_data,
//   mem_read, mem_write            - Data_Memory interface (all registered)
//   mem_read_data                  - Data_Memory read data (valid the cycle
//                                    after a MemRead pulse)
//   resp_valid/resp_ready          - response handshake
//   resp_rdata, resp_err           - load result / misalignment flag
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    state_t            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [1:0]        size_q, size_d;
    logic              is_signed_q, is_signed_d;
    logic [2:0]        offset_q, offset_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              req_ready_q, req_ready_d;

    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged_value;

    // Address bits above the dword index do not select anything in the
    // 32-entry memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[DATA_W-1:INDEX_W+3];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .offset       (offset_q),
        .size         (size_q),
        .is_signed    (is_signed_q),
        .ext_dword    (mem_read_data),
        .ext_result   (load_value),
        .merge_old    (mem_read_data),
        .merge_wdata  (wdata_q),
        .merge_result (merged_value)
    );

    // Next-state logic. Every output is registered, so each state computes
    // the output values for the state it is about to enter.
    always_comb begin
        state_d          = state_q;
        is_write_d       = is_write_q;
        size_d           = size_q;
        is_signed_d      = is_signed_q;
        offset_d         = offset_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        resp_valid_d     = resp_valid_q;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;
        req_ready_d      = req_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    is_write_d       = req_write;
                    size_d           = req_size;
                    is_signed_d      = req_signed;
                    offset_d         = req_addr[2:0];
                    wdata_d          = req_wdata;
                    mem_address_d    = DATA_W'(req_addr[INDEX_W+2:3]);
                    mem_write_data_d = req_wdata;
                    resp_rdata_d     = '0;
                    resp_err_d       = 1'b0;
                    req_ready_d      = 1'b0;
                    if (is_misaligned(req_size, req_addr[2:0])) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                    end else if (req_write && (req_size == SZ_DWORD)) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        // Loads and sub-dword stores both start by reading.
                        state_d = ST_RD_SETUP;
                    end
                end
            end
            ST_RD_SETUP: begin
                state_d    = ST_RD_STROBE;
                mem_read_d = 1'b1;
            end
            ST_RD_STROBE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                if (is_write_q) begin
                    mem_write_data_d = merged_value;
                    state_d          = ST_WR_SETUP;
                end else begin
                    resp_rdata_d = load_value;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_WR_SETUP: begin
                state_d     = ST_WR_STROBE;
                mem_write_d = 1'b1;
            end
            ST_WR_STROBE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset parks the unit in IDLE with every
    // strobe low; a write already pulsed to memory is not undone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            is_write_q       <= 1'b0;
            size_q           <= SZ_BYTE;
            is_signed_q      <= 1'b0;
            offset_q         <= 3'b000;
            wdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_err_q       <= 1'b0;
            req_ready_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            is_write_q       <= is_write_d;
            size_q           <= size_d;
            is_signed_q      <= is_signed_d;
            offset_q         <= offset_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            req_ready_q      <= req_ready_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a 32 x 64-bit Data_Memory model
// (synchronous read on MemRead, write on MemWrite). Expected values are
// worked out by hand from the little-endian byte layout.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:31];
    logic        preload;
    logic        prev_strobe = 1'b0;
    int          adjacent_strobes = 0;

    logic unused_tb_bits;
    assign unused_tb_bits = ^mem_address[63:5];

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W  (64),
        .INDEX_W (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err)
    );

    // Data_Memory model: every entry preloads to 5.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'd5;
            mem_read_data <= 64'd0;
        end else begin
            if (mem_write) mem[mem_address[4:0]] <= mem_write_data;
            if (mem_read)  mem_read_data <= mem[mem_address[4:0]];
        end
    end

    // Strobes must never be high in two consecutive cycles.
    always @(posedge clk) begin
        if ((mem_read || mem_write) && prev_strobe) adjacent_strobes++;
        prev_strobe <= mem_read || mem_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one request, then follows it cycle by cycle (k = 1 is the
    // cycle after the accept edge) until resp_valid, recording strobe
    // positions; optionally stalls the response before completing it.
    task automatic applyStimulus(input string name, input logic wr,
                                 input logic [1:0] sz, input logic sgn,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 input int exp_lat, input logic [63:0] exp_rdata,
                                 input logic exp_err, input int exp_rd_at,
                                 input int exp_wr_at, input int hold_cycles);
        int k;
        int rd_cnt;
        int wr_cnt;
        int rd_at;
        int wr_at;
        int addr_moves;
        logic [63:0] addr_seen;
        checkOutput({name, ".ready_idle"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 64'hDEAD_BEEF_0000_0000;
        req_wdata  = 64'h0;
        k = 1;
        rd_cnt = 0;
        wr_cnt = 0;
        rd_at = 0;
        wr_at = 0;
        addr_moves = 0;
        addr_seen = mem_address;
        while (!resp_valid && k <= 20) begin
            if (mem_read) begin
                rd_cnt++;
                if (rd_at == 0) rd_at = k;
            end
            if (mem_write) begin
                wr_cnt++;
                if (wr_at == 0) wr_at = k;
            end
            if (mem_address !== addr_seen) addr_moves++;
            tick();
            k++;
        end
        checkOutput({name, ".latency"}, 64'(k), 64'(exp_lat));
        checkOutput({name, ".rdata"}, resp_rdata, exp_rdata);
        checkOutput({name, ".err"}, 64'(resp_err), 64'(exp_err));
        checkOutput({name, ".reads"}, 64'(rd_cnt), 64'(exp_rd_at != 0));
        checkOutput({name, ".writes"}, 64'(wr_cnt), 64'(exp_wr_at != 0));
        checkOutput({name, ".read_at"}, 64'(rd_at), 64'(exp_rd_at));
        checkOutput({name, ".write_at"}, 64'(wr_at), 64'(exp_wr_at));
        checkOutput({name, ".addr_moves"}, 64'(addr_moves), 64'd0);
        if (!exp_err) checkOutput({name, ".index"}, addr_seen, {59'd0, addr[7:3]});
        checkOutput({name, ".ready_busy"}, 64'(req_ready), 64'd0);
        for (int h = 0; h < hold_cycles; h++) begin
            tick();
            checkOutput({name, ".hold_valid"}, 64'(resp_valid), 64'd1);
            checkOutput({name, ".hold_rdata"}, resp_rdata, exp_rdata);
            checkOutput({name, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput({name, ".done_valid"}, 64'(resp_valid), 64'd0);
        checkOutput({name, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset      = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        resp_ready = 1'b0;
        tick();
        tick();
        tick();
        preload = 1'b0;
        reset   = 1'b0;

        checkOutput("rst.req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst.mem_read", 64'(mem_read), 64'd0);
        checkOutput("rst.mem_write", 64'(mem_write), 64'd0);
        checkOutput("rst.mem_address", mem_address, 64'd0);
        checkOutput("rst.mem_write_data", mem_write_data, 64'd0);
        checkOutput("rst.resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst.resp_rdata", resp_rdata, 64'd0);
        checkOutput("rst.resp_err", 64'(resp_err), 64'd0);

        //            name      wr    size   sgn   addr       wdata                      lat rdata                     err  rd wr hold
        applyStimulus("ld18",   1'b0, 2'b11, 1'b0, 64'h18, 64'h0,                    4, 64'h5,                     1'b0, 2, 0, 0);
        applyStimulus("sd40",   1'b1, 2'b11, 1'b0, 64'h40, 64'hFFEEDDCCBBAA9988,     3, 64'h0,                     1'b0, 0, 2, 0);
        applyStimulus("lbs47",  1'b0, 2'b00, 1'b1, 64'h47, 64'h0,                    4, 64'hFFFFFFFFFFFFFFFF,      1'b0, 2, 0, 0);
        applyStimulus("lbu47",  1'b0, 2'b00, 1'b0, 64'h47, 64'h0,                    4, 64'hFF,                    1'b0, 2, 0, 0);
        applyStimulus("lhu42",  1'b0, 2'b01, 1'b0, 64'h42, 64'h0,                    4, 64'hBBAA,                  1'b0, 2, 0, 0);
        applyStimulus("lhu44",  1'b0, 2'b01, 1'b0, 64'h44, 64'h0,                    4, 64'hDDCC,                  1'b0, 2, 0, 0);
        applyStimulus("sb41",   1'b1, 2'b00, 1'b0, 64'h41, 64'h123456789ABCDE7F,     6, 64'h0,                     1'b0, 2, 5, 0);
        applyStimulus("ld40",   1'b0, 2'b11, 1'b1, 64'h40, 64'h0,                    4, 64'hFFEEDDCCBBAA7F88,      1'b0, 2, 0, 0);
        applyStimulus("lws44",  1'b0, 2'b10, 1'b1, 64'h44, 64'h0,                    4, 64'hFFFFFFFFFFEEDDCC,      1'b0, 2, 0, 0);
        applyStimulus("lbs41",  1'b0, 2'b00, 1'b1, 64'h41, 64'h0,                    4, 64'h7F,                    1'b0, 2, 0, 0);
        applyStimulus("sh21",   1'b1, 2'b01, 1'b0, 64'h21, 64'hABCD,                 1, 64'h0,                     1'b1, 0, 0, 0);
        applyStimulus("ld20",   1'b0, 2'b11, 1'b0, 64'h20, 64'h0,                    4, 64'h5,                     1'b0, 2, 0, 0);
        applyStimulus("ld44",   1'b0, 2'b11, 1'b0, 64'h44, 64'h0,                    1, 64'h0,                     1'b1, 0, 0, 0);
        applyStimulus("sh36",   1'b1, 2'b01, 1'b0, 64'h36, 64'hFFFF0000A5B6,         6, 64'h0,                     1'b0, 2, 5, 0);
        applyStimulus("ld30",   1'b0, 2'b11, 1'b0, 64'h30, 64'h0,                    4, 64'hA5B6000000000005,      1'b0, 2, 0, 0);
        applyStimulus("lws34",  1'b0, 2'b10, 1'b1, 64'h34, 64'h0,                    4, 64'hFFFFFFFFA5B60000,      1'b0, 2, 0, 0);
        applyStimulus("lhs46",  1'b0, 2'b01, 1'b1, 64'h46, 64'h0,                    4, 64'hFFFFFFFFFFFFFFEE,      1'b0, 2, 0, 3);

        // Reset during RD_STROBE of a dword load.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b11;
        req_addr  = 64'h18;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("mid.strobe_high", 64'(mem_read), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid.req_ready", 64'(req_ready), 64'd1);
        checkOutput("mid.mem_read", 64'(mem_read), 64'd0);
        checkOutput("mid.mem_write", 64'(mem_write), 64'd0);
        checkOutput("mid.mem_address", mem_address, 64'd0);
        checkOutput("mid.resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("mid.resp_rdata", resp_rdata, 64'd0);
        checkOutput("mid.resp_err", 64'(resp_err), 64'd0);
        applyStimulus("ld18b",  1'b0, 2'b11, 1'b0, 64'h18, 64'h0,                    4, 64'h5,                     1'b0, 2, 0, 0);

        checkOutput("adjacent_strobes", 64'(adjacent_strobes), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
